// File: rtl/ext_led_pkg.sv
// Shared addresses, register offsets and state types for the LED pattern sequencer.
package ext_led_pkg;

   localparam logic [31:0] EXT_LED_ADDR = 32'h8000_0000;
   localparam logic [31:0] SEQ_BASE     = 32'h8000_0100;

   localparam logic [7:0] OFF_CTRL    = 8'h00;
   localparam logic [7:0] OFF_DWELL   = 8'h04;
   localparam logic [7:0] OFF_LEN     = 8'h08;
   localparam logic [7:0] OFF_STATUS  = 8'h0C;
   localparam logic [7:0] OFF_PATTERN = 8'h20;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_LOOP = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_DONE
   } seq_state_e;

   typedef enum logic [1:0] {
      RD_NONE,
      RD_GPIO,
      RD_SEQ
   } rd_tgt_e;

endpackage

// File: rtl/ext_led_seq_regs.sv
// Sequencer register window: CTRL/DWELL/LEN/STATUS, pattern table, and the
// registered CPU read path that also covers reads of the GPIO register.
module ext_led_seq_regs
   import ext_led_pkg::*;
#(
   parameter int          NUM_PAT   = 8,
   parameter int          DWELL_W   = 24,
   parameter logic [31:0] LED_ADDR  = ext_led_pkg::EXT_LED_ADDR,
   parameter logic [31:0] BASE_ADDR = ext_led_pkg::SEQ_BASE
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [31:0]        addr_i,
   input  logic [31:0]        wdata_i,
   input  logic               rd_i,
   input  logic [3:0]         wr_i,
   input  logic [31:0]        gpio_rdata_i,
   input  logic               busy_i,
   input  logic               done_i,
   input  logic [3:0]         idx_i,
   output logic [31:0]        rdata_o,
   output logic               ctrl_wr_o,
   output logic               ctrl_en_o,
   output logic               loop_o,
   output logic [DWELL_W-1:0] dwell_o,
   output logic [4:0]         len_o,
   output logic [31:0]        pat_o
);

   localparam int         IDX_W     = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
   localparam logic [7:0] NUM_PAT_L = 8'(NUM_PAT);

   logic [1:0]         ctrl_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [4:0]         len_q;
   logic [31:0]        pat_q [NUM_PAT];
   rd_tgt_e            rd_tgt_q;
   logic [31:0]        rdata_q;

   logic               in_win;
   logic [7:0]         off;
   logic [7:0]         off_pat;
   logic               pat_hit;
   logic [IDX_W-1:0]   pat_sel;
   logic               wr_en;
   logic [31:0]        rd_val;

   assign in_win  = (addr_i[31:8] == BASE_ADDR[31:8]);
   assign off     = addr_i[7:0];
   assign off_pat = off - OFF_PATTERN;
   assign pat_hit = in_win && (off >= OFF_PATTERN) && (off_pat[1:0] == 2'b00)
                    && ({2'b00, off_pat[7:2]} < NUM_PAT_L);
   assign pat_sel = off_pat[IDX_W+1:2];

   // A read in the same cycle as a write takes priority; the write is dropped.
   assign wr_en     = in_win && (|wr_i) && !rd_i;
   assign ctrl_wr_o = wr_en && (off == OFF_CTRL);
   assign ctrl_en_o = wdata_i[CTRL_EN];

   assign loop_o  = ctrl_q[CTRL_LOOP];
   assign dwell_o = dwell_q;
   assign len_o   = len_q;
   assign pat_o   = pat_q[idx_i[IDX_W-1:0]];

   always_comb begin
      rd_val = '0;
      if (in_win) begin
         case (off)
            OFF_CTRL:   rd_val = {30'b0, ctrl_q};
            OFF_DWELL:  rd_val = 32'(dwell_q);
            OFF_LEN:    rd_val = {27'b0, len_q};
            OFF_STATUS: rd_val = {24'b0, idx_i, 2'b00, done_i, busy_i};
            default:    rd_val = '0;
         endcase
         if (pat_hit) rd_val = pat_q[pat_sel];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q   <= '0;
         dwell_q  <= '0;
         len_q    <= '0;
         for (int i = 0; i < NUM_PAT; i++) pat_q[i] <= '0;
         rd_tgt_q <= RD_NONE;
         rdata_q  <= '0;
      end else begin
         if (wr_en) begin
            case (off)
               OFF_CTRL:  ctrl_q  <= wdata_i[1:0];
               OFF_DWELL: dwell_q <= wdata_i[DWELL_W-1:0];
               OFF_LEN:   len_q   <= wdata_i[4:0];
               default:   ;
            endcase
            if (pat_hit) pat_q[pat_sel] <= wdata_i;
         end
         if (rd_i) begin
            if (addr_i == LED_ADDR) begin
               rd_tgt_q <= RD_GPIO;
            end else if (in_win) begin
               rd_tgt_q <= RD_SEQ;
               rdata_q  <= rd_val;
            end else begin
               rd_tgt_q <= RD_NONE;
            end
         end
      end
   end

   // GPIO data is already registered in the GPIO unit, so only the target is held here.
   always_comb begin
      case (rd_tgt_q)
         RD_GPIO: rdata_o = gpio_rdata_i;
         RD_SEQ:  rdata_o = rdata_q;
         default: rdata_o = '0;
      endcase
   end

endmodule

// File: rtl/ext_led_seq.sv
// LED pattern sequencer and CPU/sequencer arbiter in front of the GPIO LED register.
module ext_led_seq
   import ext_led_pkg::*;
#(
   parameter int          NUM_PAT      = 8,
   parameter int          DWELL_W      = 24,
   parameter logic [31:0] EXT_LED_ADDR = ext_led_pkg::EXT_LED_ADDR,
   parameter logic [31:0] SEQ_BASE     = ext_led_pkg::SEQ_BASE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_data_in,
   input  logic        cpu_rd_strobe,
   input  logic [3:0]  cpu_wr_strobe,
   output logic [31:0] cpu_data_out,
   output logic [31:0] gpio_addr,
   output logic [31:0] gpio_data_in,
   output logic        gpio_rd_strobe,
   output logic [3:0]  gpio_wr_strobe,
   input  logic [31:0] gpio_data_out,
   output logic        seq_busy,
   output logic        seq_done
);

   localparam logic [4:0] NUM_PAT_L = 5'(NUM_PAT);

   seq_state_e         state_q, state_d;
   logic [3:0]         idx_q, idx_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;

   logic               ctrl_wr, ctrl_en, loop;
   logic [DWELL_W-1:0] dwell;
   logic [4:0]         len;
   logic [31:0]        pat;
   logic [4:0]         eff_len;
   logic               cpu_gpio;
   logic               last_pat;
   logic               seq_wr;

   ext_led_seq_regs #(
      .NUM_PAT   (NUM_PAT),
      .DWELL_W   (DWELL_W),
      .LED_ADDR  (EXT_LED_ADDR),
      .BASE_ADDR (SEQ_BASE)
   ) u_regs (
      .clk_i        (clk),
      .rst_i        (rst),
      .addr_i       (cpu_addr),
      .wdata_i      (cpu_data_in),
      .rd_i         (cpu_rd_strobe),
      .wr_i         (cpu_wr_strobe),
      .gpio_rdata_i (gpio_data_out),
      .busy_i       (seq_busy),
      .done_i       (seq_done),
      .idx_i        (idx_q),
      .rdata_o      (cpu_data_out),
      .ctrl_wr_o    (ctrl_wr),
      .ctrl_en_o    (ctrl_en),
      .loop_o       (loop),
      .dwell_o      (dwell),
      .len_o        (len),
      .pat_o        (pat)
   );

   assign eff_len  = (len > NUM_PAT_L) ? NUM_PAT_L : len;
   assign cpu_gpio = (cpu_addr == EXT_LED_ADDR) && (cpu_rd_strobe || (|cpu_wr_strobe));
   // Also true when LEN was lowered below idx+1 while running.
   assign last_pat = (({1'b0, idx_q} + 5'd1) >= eff_len);

   assign seq_busy = (state_q == ST_LOAD) || (state_q == ST_WAIT);
   assign seq_done = (state_q == ST_DONE);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      seq_wr  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (ctrl_wr && ctrl_en) begin
               idx_d   = '0;
               state_d = (eff_len == 5'd0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (!cpu_gpio) begin
               seq_wr  = 1'b1;
               cnt_d   = dwell;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               if (!last_pat) begin
                  idx_d   = idx_q + 4'd1;
                  state_d = ST_LOAD;
               end else if (loop) begin
                  idx_d   = '0;
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (ctrl_wr && !ctrl_en) state_d = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // CPU traffic to the LED register always wins over the sequencer.
   always_comb begin
      gpio_addr      = EXT_LED_ADDR;
      gpio_data_in   = '0;
      gpio_rd_strobe = 1'b0;
      gpio_wr_strobe = 4'h0;
      if (!rst) begin
         if (cpu_gpio) begin
            gpio_addr      = cpu_addr;
            gpio_data_in   = cpu_data_in;
            gpio_rd_strobe = cpu_rd_strobe;
            gpio_wr_strobe = cpu_rd_strobe ? 4'h0 : cpu_wr_strobe;
         end else if (seq_wr) begin
            gpio_data_in   = pat;
            gpio_wr_strobe = 4'hF;
         end
      end
   end

endmodule

// File: tb/tb_ext_led_seq.sv
// Bench for ext_led_seq: directed scenarios with literal expectations, then random
// traffic checked every cycle against a schedule-based model of the sequencer.
module tb_ext_led_seq;

   localparam logic [31:0] LED  = 32'h8000_0000;
   localparam logic [31:0] BASE = 32'h8000_0100;
   localparam int          NP   = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cpu_addr = '0, cpu_data_in = '0;
   logic        cpu_rd_strobe = 1'b0;
   logic [3:0]  cpu_wr_strobe = 4'h0;
   logic [31:0] cpu_data_out, gpio_addr, gpio_data_in, gpio_data_out;
   logic        gpio_rd_strobe, seq_busy, seq_done;
   logic [3:0]  gpio_wr_strobe;

   always #5 clk = ~clk;

   ext_led_seq dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_addr       (cpu_addr),
      .cpu_data_in    (cpu_data_in),
      .cpu_rd_strobe  (cpu_rd_strobe),
      .cpu_wr_strobe  (cpu_wr_strobe),
      .cpu_data_out   (cpu_data_out),
      .gpio_addr      (gpio_addr),
      .gpio_data_in   (gpio_data_in),
      .gpio_rd_strobe (gpio_rd_strobe),
      .gpio_wr_strobe (gpio_wr_strobe),
      .gpio_data_out  (gpio_data_out),
      .seq_busy       (seq_busy),
      .seq_done       (seq_done)
   );

   // Stand-in for the GPIO unit: one register, read data registered.
   logic [31:0] gpio_q = '0;
   always @(posedge clk) if (gpio_wr_strobe != 4'h0) gpio_q <= gpio_data_in;
   assign gpio_data_out = gpio_q;

   int passed = 0, total = 0, cyc = 0;
   int log_t[$];
   logic [31:0] log_d[$];

   // Model: a write is "pending" until it gets the bus, then a dwell of DWELL+1 cycles.
   bit          m_pend, m_dwel, m_done, m_en, m_loop;
   int          m_wait, m_idx, m_dwell, m_len, m_rdk;
   logic [31:0] m_pat [NP];
   logic [31:0] m_rdv, m_led = '0;
   logic [31:0] e_din;
   logic [3:0]  e_wr;
   bit          e_rd;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic void model_reset();
      m_pend = 0; m_dwel = 0; m_done = 0; m_en = 0; m_loop = 0;
      m_wait = 0; m_idx = 0; m_dwell = 0; m_len = 0; m_rdk = 0; m_rdv = '0;
      for (int i = 0; i < NP; i++) m_pat[i] = '0;
   endfunction

   function automatic bit in_win(logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'd256);
   endfunction

   function automatic logic [31:0] reg_read(logic [31:0] a);
      int off;
      off = int'(a - BASE);
      if (off == 0)  return {30'b0, m_loop, m_en};
      if (off == 4)  return 32'(m_dwell);
      if (off == 8)  return 32'(m_len);
      if (off == 12) return 32'((m_idx << 4) | (int'(m_done) << 1) | int'(m_pend || m_dwel));
      if (off >= 32 && off < 32 + 4 * NP && off % 4 == 0) return m_pat[(off - 32) / 4];
      return '0;
   endfunction

   task automatic compare();
      bit cg;
      logic [31:0] e_cdo;
      cg = (cpu_addr == LED) && (cpu_rd_strobe || cpu_wr_strobe != 4'h0);
      e_din = '0; e_wr = 4'h0; e_rd = 0;
      if (!rst) begin
         if (cg) begin
            e_din = cpu_data_in; e_rd = cpu_rd_strobe;
            e_wr = cpu_rd_strobe ? 4'h0 : cpu_wr_strobe;
         end else if (m_pend) begin
            e_din = m_pat[m_idx]; e_wr = 4'hF;
         end
      end
      e_cdo = (m_rdk == 1) ? m_led : (m_rdk == 2) ? m_rdv : '0;
      chk("gpio_addr", gpio_addr, LED);
      chk("gpio_data_in", gpio_data_in, e_din);
      chk("gpio_wr_strobe", 32'(gpio_wr_strobe), 32'(e_wr));
      chk("gpio_rd_strobe", 32'(gpio_rd_strobe), 32'(e_rd));
      chk("seq_busy", 32'(seq_busy), 32'(m_pend || m_dwel));
      chk("seq_done", 32'(seq_done), 32'(m_done));
      chk("cpu_data_out", cpu_data_out, e_cdo);
   endtask

   task automatic step();
      bit cg, wr_ok, ctrl_w, seqw;
      int eff, off;
      if (e_wr != 4'h0) m_led = e_din;
      if (rst) begin model_reset(); return; end
      cg     = (cpu_addr == LED) && (cpu_rd_strobe || cpu_wr_strobe != 4'h0);
      seqw   = m_pend && !cg;
      wr_ok  = (cpu_wr_strobe != 4'h0) && !cpu_rd_strobe && in_win(cpu_addr);
      ctrl_w = wr_ok && (cpu_addr == BASE);
      eff    = (m_len > NP) ? NP : m_len;
      if (cpu_rd_strobe) begin
         if (cpu_addr == LED) m_rdk = 1;
         else if (in_win(cpu_addr)) begin m_rdk = 2; m_rdv = reg_read(cpu_addr); end
         else m_rdk = 0;
      end
      if (seqw) begin
         m_pend = 0; m_dwel = 1; m_wait = m_dwell;
      end else if (m_dwel) begin
         if (m_wait == 0) begin
            m_dwel = 0;
            if (m_idx + 1 < eff) begin m_idx++; m_pend = 1; end
            else if (m_loop) begin m_idx = 0; m_pend = 1; end
            else m_done = 1;
         end else m_wait--;
      end else if (!m_pend && ctrl_w && cpu_data_in[0]) begin
         m_idx = 0;
         if (eff == 0) m_done = 1;
         else begin m_done = 0; m_pend = 1; end
      end
      if (ctrl_w && !cpu_data_in[0]) begin m_pend = 0; m_dwel = 0; m_done = 0; end
      if (wr_ok) begin
         off = int'(cpu_addr - BASE);
         if (off == 0) begin m_en = cpu_data_in[0]; m_loop = cpu_data_in[1]; end
         if (off == 4) m_dwell = int'(cpu_data_in[23:0]);
         if (off == 8) m_len = int'(cpu_data_in[4:0]);
         if (off >= 32 && off < 32 + 4 * NP && off % 4 == 0) m_pat[(off - 32) / 4] = cpu_data_in;
      end
   endtask

   task automatic cycle(input bit r, input logic [31:0] a, input logic [31:0] d,
                        input bit rd, input logic [3:0] wr);
      @(negedge clk);
      rst = r; cpu_addr = a; cpu_data_in = d; cpu_rd_strobe = rd; cpu_wr_strobe = wr;
      #1;
      compare();
      if (gpio_wr_strobe != 4'h0) begin log_t.push_back(cyc); log_d.push_back(gpio_data_in); end
      @(posedge clk);
      #1;
      step();
      cyc++;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d); cycle(0, a, d, 0, 4'hF); endtask
   task automatic rdreg(input logic [31:0] a); cycle(0, a, '0, 1, 4'h0); endtask
   task automatic idle(input int n); for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, 4'h0); endtask
   task automatic clear_log(); log_t.delete(); log_d.delete(); endtask

   initial begin
      int t0, op;
      logic [31:0] a;
      model_reset();

      cycle(1, '0, '0, 0, 4'h0);
      cycle(1, '0, '0, 0, 4'h0);
      idle(1);
      rdreg(BASE + 32'h0C);
      chk("reset_status", cpu_data_out, 32'h0);
      chk("reset_busy", 32'(seq_busy), 32'h0);
      chk("reset_done", 32'(seq_done), 32'h0);
      rdreg(BASE + 32'h20);
      chk("reset_pattern0", cpu_data_out, 32'h0);

      wr(BASE + 32'h20, 32'h11); wr(BASE + 32'h24, 32'h0A); wr(BASE + 32'h28, 32'h1F);
      wr(BASE + 32'h04, 32'd3);  wr(BASE + 32'h08, 32'd3);
      clear_log(); t0 = cyc;
      wr(BASE, 32'h1);
      idle(25);
      chk("run_count", 32'(log_d.size()), 32'd3);
      if (log_d.size() == 3) begin
         chk("run_w0", log_d[0], 32'h11); chk("run_w1", log_d[1], 32'h0A); chk("run_w2", log_d[2], 32'h1F);
         chk("run_first_lat", 32'(log_t[0] - t0), 32'd1);
         chk("run_gap1", 32'(log_t[1] - log_t[0]), 32'd5);
         chk("run_gap2", 32'(log_t[2] - log_t[1]), 32'd5);
      end
      rdreg(BASE + 32'h0C);
      chk("done_status", cpu_data_out, 32'h22);
      chk("done_flag", 32'(seq_done), 32'h1);

      clear_log();
      wr(BASE, 32'h3);
      idle(19);
      chk("loop_count", 32'(log_d.size()), 32'd4);
      if (log_d.size() == 4) chk("loop_wrap", log_d[3], 32'h11);
      wr(BASE, 32'h0);
      clear_log();
      idle(15);
      chk("stop_writes", 32'(log_d.size()), 32'd0);
      chk("stop_busy", 32'(seq_busy), 32'h0);
      chk("stop_done", 32'(seq_done), 32'h0);

      clear_log(); t0 = cyc;
      wr(BASE, 32'h1);
      cycle(0, LED, 32'h05, 0, 4'hF);
      idle(20);
      chk("stall_count", 32'(log_d.size()), 32'd4);
      if (log_d.size() == 4) begin
         chk("stall_cpu", log_d[0], 32'h05);  chk("stall_cpu_t", 32'(log_t[0] - t0), 32'd1);
         chk("stall_seq", log_d[1], 32'h11);  chk("stall_seq_t", 32'(log_t[1] - t0), 32'd2);
         chk("stall_w2_t", 32'(log_t[2] - t0), 32'd7);
         chk("stall_w3_t", 32'(log_t[3] - t0), 32'd12);
      end

      wr(BASE, 32'h0); wr(BASE + 32'h08, 32'd0);
      clear_log();
      wr(BASE, 32'h1);
      chk("len0_done", 32'(seq_done), 32'h1);
      chk("len0_busy", 32'(seq_busy), 32'h0);
      idle(3);
      chk("len0_writes", 32'(log_d.size()), 32'd0);
      wr(BASE + 32'h08, 32'd20); wr(BASE, 32'h0);
      clear_log();
      wr(BASE, 32'h1);
      idle(50);
      chk("len20_writes", 32'(log_d.size()), 32'd8);
      chk("len20_done", 32'(seq_done), 32'h1);

      cycle(0, BASE + 32'h04, 32'h55, 1, 4'hF);
      chk("rdwr_old", cpu_data_out, 32'd3);
      rdreg(BASE + 32'h04);
      chk("rdwr_kept", cpu_data_out, 32'd3);
      rdreg(BASE + 32'h10);
      chk("unmapped", cpu_data_out, 32'h0);

      for (int n = 0; n < 4000; n++) begin
         op = $urandom_range(0, 99);
         if (op < 2) cycle(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         else if (op < 25) idle(1);
         else if (op < 35) wr(BASE, ($urandom_range(0, 3) == 0) ? 32'h0 : 32'(1 | ($urandom_range(0, 1) << 1)));
         else if (op < 42) wr(BASE + 32'h04, 32'($urandom_range(0, 5)));
         else if (op < 48) wr(BASE + 32'h08, 32'($urandom_range(0, 12)));
         else if (op < 58) wr(BASE + 32'h20 + 32'(4 * $urandom_range(0, 9)), $urandom);
         else if (op < 70) rdreg(BASE + 32'($urandom_range(0, 63)));
         else if (op < 80) cycle(0, LED, $urandom, 0, 4'($urandom_range(1, 15)));
         else if (op < 85) rdreg(LED);
         else if (op < 90) begin
            a = ($urandom_range(0, 1) == 0) ? LED : BASE + 32'(4 * $urandom_range(0, 1));
            cycle(0, a, $urandom, 1, 4'($urandom_range(1, 15)));
         end else if (op < 95) begin
            a = ($urandom_range(0, 1) == 0) ? 32'h8000_0200 : 32'h0;
            cycle(0, a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         end else idle(1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
